// File: rtl/serial_bit_feeder_pkg.sv
// Shared definitions for the serial bit feeder: FSM encoding and parameter defaults.
package serial_bit_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam int   WIDTH_DEF      = 8;
  localparam bit   MSB_FIRST_DEF  = 1'b1;
  localparam logic IDLE_LEVEL_DEF = 1'b0;

endpackage

// File: rtl/serial_bit_feeder_if.sv
// Load/ready word handshake plus serial bit stream toward the sequence detector.
interface serial_bit_feeder_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] data_in;
  logic             load;
  logic             ready;
  logic             x_out;
  logic             x_valid;
  logic             done;

  modport master (output data_in, load, input ready, x_out, x_valid, done);
  modport slave  (input data_in, load, output ready, x_out, x_valid, done);
endinterface

// File: rtl/serial_bit_feeder_counter.sv
// Loadable down-counter with terminal-count flag; holds at zero instead of wrapping.
module bit_down_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [CW-1:0] load_val,
  input  logic          dec_en,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      cnt <= '0;
    else if (load_en)              cnt <= load_val;
    else if (dec_en && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder; all outputs decode from registers so the downstream
// Mealy detector never sees a combinational path back to load/data_in.
module serial_bit_feeder
  import serial_bit_feeder_pkg::*;
#(
  parameter int   WIDTH      = WIDTH_DEF,
  parameter bit   MSB_FIRST  = MSB_FIRST_DEF,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic               clk,
  input  logic               rst,
  serial_bit_feeder_if.slave bus
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_shift;
  logic [CW-1:0]    cnt;
  logic             tc, cap, dec;
  logic             ready_c, x_valid_c, done_c, x_out_c;

  bit_down_counter #(.CW(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load_en  (cap),
    .load_val (CNT_LAST),
    .dec_en   (dec),
    .cnt      (cnt),
    .tc       (tc)
  );

  // Zero fill keeps residual bits from leaking once the frame has drained.
  assign shreg_shift = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
  assign dec         = (state == ST_SHIFT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   shreg <= '0;
    else if (cap)               shreg <= bus.data_in;
    else if (state == ST_SHIFT) shreg <= shreg_shift;
  end

  always_comb begin
    state_nxt = state;
    cap       = 1'b0;
    ready_c   = 1'b0;
    x_valid_c = 1'b0;
    done_c    = 1'b0;
    x_out_c   = IDLE_LEVEL;
    case (state)
      ST_IDLE: begin
        ready_c = 1'b1;
        if (bus.load) begin
          cap       = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        x_valid_c = 1'b1;
        x_out_c   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
        if (tc) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        ready_c = 1'b1;
        done_c  = 1'b1;
        if (bus.load) begin
          cap       = 1'b1;
          state_nxt = ST_SHIFT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.ready   = ready_c;
  assign bus.x_valid = x_valid_c;
  assign bus.done    = done_c;
  assign bus.x_out   = x_out_c;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench: MSB-first feeder plus an LSB-first feeder driving a small 111 detector.
module tb_serial_bit_feeder;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   done_cnt;
  logic [1:0] ones;
  logic z;

  serial_bit_feeder_if #(.WIDTH(8)) a ();
  serial_bit_feeder_if #(.WIDTH(8)) b ();

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
    .clk (clk), .rst (rst), .bus (a.slave)
  );
  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_b (
    .clk (clk), .rst (rst), .bus (b.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Overlapping "111" Mealy detector standing in for the downstream consumer.
  always @(posedge clk or negedge rst) begin
    if (!rst)                     ones <= 2'd0;
    else if (b.x_valid && b.x_out) ones <= (ones == 2'd2) ? 2'd2 : ones + 2'd1;
    else                          ones <= 2'd0;
  end
  assign z = b.x_valid && b.x_out && (ones == 2'd2);

  always @(posedge clk) if (a.done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_a(input logic [7:0] d);
    @(negedge clk);
    a.data_in = d;
    a.load    = 1'b1;
    @(posedge clk);
    #1 a.load = 1'b0;
  endtask

  // seq lists the expected stream with the first bit in seq[7].
  task automatic stream_a(input string tag, input logic [7:0] seq, input int inject_at);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk({tag, "_bit"},   32'(a.x_out),   32'(seq[7-i]));
      chk({tag, "_valid"}, 32'(a.x_valid), 32'd1);
      chk({tag, "_done0"}, 32'(a.done),    32'd0);
      chk({tag, "_busy"},  32'(a.ready),   32'd0);
      if (i == inject_at) begin
        a.data_in = 8'hFF;
        a.load    = 1'b1;
      end else if (inject_at >= 0 && i == inject_at + 1) begin
        a.load    = 1'b0;
      end
    end
    @(negedge clk);
    chk({tag, "_done"},   32'(a.done),    32'd1);
    chk({tag, "_dvalid"}, 32'(a.x_valid), 32'd0);
    chk({tag, "_dxout"},  32'(a.x_out),   32'd0);
    chk({tag, "_dready"}, 32'(a.ready),   32'd1);
  endtask

  initial begin
    logic [7:0] seq_b;
    logic [7:0] z_b;
    n_tests  = 0;
    n_fail   = 0;
    done_cnt = 0;
    rst      = 1'b1;
    a.data_in = '0; a.load = 1'b0;
    b.data_in = '0; b.load = 1'b0;

    #2 rst = 1'b0;
    #1;
    chk("rst_in_ready_a",  32'(a.ready),   32'd1);
    chk("rst_in_valid_a",  32'(a.x_valid), 32'd0);
    chk("rst_in_done_a",   32'(a.done),    32'd0);
    chk("rst_in_xout_a",   32'(a.x_out),   32'd0);
    chk("rst_in_ready_b",  32'(b.ready),   32'd1);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_out_ready",   32'(a.ready),   32'd1);
    chk("rst_out_valid",   32'(a.x_valid), 32'd0);
    chk("rst_out_done",    32'(a.done),    32'd0);
    chk("rst_out_xout",    32'(a.x_out),   32'd0);

    // Single MSB-first frame
    load_a(8'b1011_0010);
    stream_a("single", 8'b1011_0010, -1);
    @(negedge clk);
    chk("single_idle_valid", 32'(a.x_valid), 32'd0);
    chk("single_idle_done",  32'(a.done),    32'd0);

    // Back-to-back frames with load held high
    done_cnt = 0;
    @(negedge clk);
    a.data_in = 8'hA5;
    a.load    = 1'b1;
    @(posedge clk);
    #1 a.data_in = 8'h3C;
    stream_a("b2b0", 8'hA5, -1);
    @(posedge clk);
    #1 a.load = 1'b0;
    stream_a("b2b1", 8'h3C, -1);
    @(negedge clk);
    chk("b2b_idle_valid", 32'(a.x_valid), 32'd0);
    chk("b2b_done_count", 32'(done_cnt),  32'd2);

    // Load during a frame is ignored
    load_a(8'h00);
    stream_a("ign", 8'h00, 3);
    @(negedge clk);
    chk("ign_no_frame", 32'(a.x_valid), 32'd0);
    chk("ign_ready",    32'(a.ready),   32'd1);

    // Abort mid-frame with reset
    done_cnt = 0;
    load_a(8'hFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_pre_bit", 32'(a.x_out), 32'd1);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_valid", 32'(a.x_valid), 32'd0);
    chk("abort_xout",  32'(a.x_out),   32'd0);
    chk("abort_ready", 32'(a.ready),   32'd1);
    chk("abort_done",  32'(a.done),    32'd0);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_quiet_valid", 32'(a.x_valid), 32'd0);
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    load_a(8'h81);
    stream_a("reload", 8'b1000_0001, -1);

    // LSB-first feeder driving the detector
    seq_b = 8'b1110_0000;
    z_b   = 8'b0010_0000;
    @(negedge clk);
    b.data_in = 8'h07;
    b.load    = 1'b1;
    @(posedge clk);
    #1 b.load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("lsb_bit",   32'(b.x_out),   32'(seq_b[7-i]));
      chk("lsb_valid", 32'(b.x_valid), 32'd1);
      chk("det_z",     32'(z),         32'(z_b[7-i]));
    end
    @(negedge clk);
    chk("lsb_done",   32'(b.done),    32'd1);
    chk("lsb_dvalid", 32'(b.x_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
